// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the memory controller: state encoding,
// word/address widths and the even-parity helper.
package memory_controller_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Request/response bus between the control unit (master) and the
// memory controller (slave).
interface memory_controller_if;
  import memory_controller_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              mem_err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, mem_err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, mem_err
  );

endinterface

// File: rtl/memory_controller_wait_counter.sv
// Wait-state down-counter: load a start value, decrement to zero, flag zero.
module wait_counter
  import memory_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memory_controller.sv
// Single-port word memory behind an IDLE/WAIT/RESP request FSM.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic                clk,
  input logic                rst_n,
  memory_controller_if.slave bus
);

  localparam int                AW_I    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_LD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [AW_I-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_e               op_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic              req_one, addr_ok, accept, reject;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              busy, resp, resp_wr, resp_rd, par_err;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Request qualification happens only in IDLE; inputs are ignored elsewhere.
  assign req_one = bus.mem_read ^ bus.mem_write;
  assign addr_ok = ({1'b0, bus.addr} < DEPTH_L);
  assign accept  = (state_q == ST_IDLE) && req_one && addr_ok;
  assign reject  = (state_q == ST_IDLE) && (bus.mem_read || bus.mem_write) && !accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_zero) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state_q != ST_IDLE);
    resp     = (state_q == ST_RESP);
    resp_wr  = resp && (op_q == OP_WRITE);
    resp_rd  = resp && (op_q == OP_READ);
    cnt_load = accept;
    cnt_dec  = (state_q == ST_WAIT);
  end

  wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (WAIT_LD),
    .zero_o     (cnt_zero)
  );

  // Transaction latch: values captured at acceptance drive the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (accept) begin
      addr_q  <= bus.addr[AW_I-1:0];
      wdata_q <= bus.wdata;
      op_q    <= bus.mem_write ? OP_WRITE : OP_READ;
    end
  end

  // Array contents survive reset; an aborted write never reaches RESP.
  always_ff @(posedge clk) begin
    if (resp_wr) mem_q[addr_q] <= wdata_q;
  end

`ifdef MEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (resp_wr) par_q[addr_q] <= parity_f(wdata_q);
  end

  assign par_err = resp_rd && (par_q[addr_q] != parity_f(mem_q[addr_q]));
`else
  assign par_err = 1'b0;
`endif

  // ready/rdata land together on the edge that leaves RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= resp;
      err_q   <= reject || par_err;
      if (resp_rd) rdata_q <= mem_q[addr_q];
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy;
  assign bus.mem_err = err_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: three controller instances (WS=1/D=1024, WS=0/D=512,
// WS=3/D=1024) sharing one clock, each with its own reset.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn [3];
  logic              rd   [3];
  logic              wr   [3];
  logic [ADDR_W-1:0] ad   [3];
  logic [DATA_W-1:0] wd   [3];
  logic [DATA_W-1:0] rdat [3];
  logic              rdy  [3];
  logic              bsy  [3];
  logic              err  [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS_G = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    localparam int DP_G = (g == 1) ? 512 : 1024;

    memory_controller_if mif ();

    assign mif.mem_read  = rd[g];
    assign mif.mem_write = wr[g];
    assign mif.addr      = ad[g];
    assign mif.wdata     = wd[g];
    assign rdat[g]       = mif.rdata;
    assign rdy[g]        = mif.ready;
    assign bsy[g]        = mif.busy;
    assign err[g]        = mif.mem_err;

    memory_controller #(.DEPTH(DP_G), .WAIT_STATES(WS_G)) dut (
      .clk   (clk),
      .rst_n (rstn[g]),
      .bus   (mif)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted transaction; returns at the cycle where ready is high.
  task automatic xfer(input int d, input logic r, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] data,
                      input int exp_lat, input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = data;
    @(posedge clk);
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0;
    chk({tag, "_busy_in_flight"}, 32'(bsy[d]), 32'd1);
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err_at_ready"}, 32'(err[d]), 32'(exp_err));
    chk({tag, "_busy_at_ready"}, 32'(bsy[d]), 32'd0);
  endtask

  // Rejected request: mem_err for one cycle, no ready, never busy.
  task automatic reject(input int d, input logic r, input logic w,
                        input logic [ADDR_W-1:0] a, input string tag);
    @(negedge clk);
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = 20'h11111;
    @(posedge clk);
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0;
    chk({tag, "_err_pulse"}, 32'(err[d]), 32'd1);
    chk({tag, "_no_ready"}, 32'(rdy[d]), 32'd0);
    chk({tag, "_not_busy"}, 32'(bsy[d]), 32'd0);
    @(negedge clk);
    chk({tag, "_err_clear"}, 32'(err[d]), 32'd0);
    chk({tag, "_no_ready_late"}, 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    #12;
    chk("rst_rdata", 32'(rdat[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

    // WS=1: write then read back, ready two cycles after each acceptance
    xfer(0, 1'b0, 1'b1, 10'h005, 20'hABCDE, 2, 1'b0, "ws1_wr");
    chk("ws1_wr_rdata_untouched", 32'(rdat[0]), 32'd0);
    xfer(0, 1'b1, 1'b0, 10'h005, 20'h00000, 2, 1'b0, "ws1_rd");
    chk("ws1_rd_data", 32'(rdat[0]), 32'hABCDE);

    // Both requests at once: rejected, array untouched
    reject(0, 1'b1, 1'b1, 10'h005, "both");
    chk("both_rdata_hold", 32'(rdat[0]), 32'hABCDE);
    xfer(0, 1'b1, 1'b0, 10'h005, 20'h00000, 2, 1'b0, "both_rd");
    chk("both_array_unchanged", 32'(rdat[0]), 32'hABCDE);

    // Top word of a full-depth array
    xfer(0, 1'b0, 1'b1, 10'h3FF, 20'h55555, 2, 1'b0, "top_wr");
    xfer(0, 1'b1, 1'b0, 10'h3FF, 20'h00000, 2, 1'b0, "top_rd");
    chk("top_rd_data", 32'(rdat[0]), 32'h55555);

    // WS=0: preload addr 0, reset, then read with single-cycle busy
    xfer(1, 1'b0, 1'b1, 10'h000, 20'h12345, 1, 1'b0, "ws0_wr");
    @(negedge clk);
    rstn[1] = 1'b0;
    #1;
    chk("ws0_rst_rdata", 32'(rdat[1]), 32'd0);
    @(negedge clk);
    rstn[1] = 1'b1;
    xfer(1, 1'b1, 1'b0, 10'h000, 20'h00000, 1, 1'b0, "ws0_rd");
    chk("ws0_rd_data", 32'(rdat[1]), 32'h12345);

    // DEPTH=512: address 0x200 is out of range
    reject(1, 1'b1, 1'b0, 10'h200, "oor");
    chk("oor_rdata_hold", 32'(rdat[1]), 32'h12345);
    xfer(1, 1'b1, 1'b0, 10'h1FF, 20'h00000, 1, 1'b0, "last_rd");

    // WS=3: establish old value, then abort a write with reset mid-WAIT
    xfer(2, 1'b0, 1'b1, 10'h007, 20'h0BEEF, 4, 1'b0, "ws3_wr");
    xfer(2, 1'b1, 1'b0, 10'h007, 20'h00000, 4, 1'b0, "ws3_rd");
    chk("ws3_rd_data", 32'(rdat[2]), 32'h0BEEF);
    @(negedge clk);
    wr[2] = 1'b1; ad[2] = 10'h007; wd[2] = 20'h00001;
    @(posedge clk);
    @(negedge clk);
    wr[2] = 1'b0; ad[2] = '0; wd[2] = '0;
    chk("abort_busy", 32'(bsy[2]), 32'd1);
    @(posedge clk);
    #2 rstn[2] = 1'b0;
    #1;
    chk("abort_rdata", 32'(rdat[2]), 32'd0);
    chk("abort_ready", 32'(rdy[2]), 32'd0);
    chk("abort_busy_clr", 32'(bsy[2]), 32'd0);
    chk("abort_err", 32'(err[2]), 32'd0);
    @(negedge clk);
    rstn[2] = 1'b1;
    xfer(2, 1'b1, 1'b0, 10'h007, 20'h00000, 4, 1'b0, "abort_rd");
    chk("abort_old_value", 32'(rdat[2]), 32'h0BEEF);

`ifdef MEM_PARITY_EN
    xfer(0, 1'b0, 1'b1, 10'h003, 20'h00003, 2, 1'b0, "par_wr");
    g_dut[0].dut.par_q[3] = ~g_dut[0].dut.par_q[3];
    xfer(0, 1'b1, 1'b0, 10'h003, 20'h00000, 2, 1'b1, "par_rd");
    chk("par_rd_data", 32'(rdat[0]), 32'h00003);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
